regbus_arbiter: RTL and testbench

Shares the single 32-bit internal register bus (20-bit word address, byte strobes, en/ack handshake) between two bus masters: master 0 is the board-manager UART bridge and master 1 is a second control path. Fair round-robin grant, one transaction at a time, plus an ack watchdog so a dead slave cannot hang a master. Sits between the masters and the register decode.

---
 rtl/regbus_arbiter.sv | 128 ++++++++++++
 tb/tb_regbus_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter sharing the internal register bus between two masters,
// with an ack watchdog that force-completes transactions to a dead slave.
//
// state | meaning
// IDLE  | no transaction; arbitrate among requesting masters
// BUSY  | granted master drives the slave bus until ack, timeout or abort
// GAP   | one dead cycle so the finished master can drop en before re-arbitration
module regbus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hBADACCE5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic        m0_en_i,
   input  logic        m0_wr_i,
   input  logic [3:0]  m0_wstrb_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   input  logic [19:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic        m1_en_i,
   input  logic        m1_wr_i,
   input  logic [3:0]  m1_wstrb_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic [19:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic        s_en_o,
   output logic        s_wr_o,
   output logic [3:0]  s_wstrb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   output logic        timeout_o,
   output logic [7:0]  timeout_count_o
);

   localparam int unsigned WDW = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

   state_t         state_q;
   logic           grant_q;
   logic           last_q;
   logic [WDW-1:0] wdog_q;
   logic           timeout_q;
   logic [7:0]     tcount_q;

   logic        busy;
   logic        gnt_en;
   logic        ack_ok;
   logic        ack_tmo;
   logic        done;
   logic [31:0] rdata;

   assign busy    = (state_q == BUSY);
   assign gnt_en  = grant_q ? m1_en_i : m0_en_i;
   // A real ack on the watchdog's last cycle wins over the forced completion.
   assign ack_ok  = busy & gnt_en & s_ack_i;
   assign ack_tmo = busy & gnt_en & ~s_ack_i & (wdog_q == WD_LAST);
   assign done    = ack_ok | ack_tmo;
   assign rdata   = ack_ok ? s_dat_i : TIMEOUT_DATA;

   assign m0_ack_o = done & ~grant_q;
   assign m1_ack_o = done & grant_q;
   assign m0_dat_o = m0_ack_o ? rdata : '0;
   assign m1_dat_o = m1_ack_o ? rdata : '0;

   assign timeout_o       = timeout_q;
   assign timeout_count_o = tcount_q;

   always_comb begin
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_en_o    = 1'b0;
      s_wr_o    = 1'b0;
      s_wstrb_o = '0;
      if (busy) begin
         s_adr_o   = grant_q ? m1_adr_i   : m0_adr_i;
         s_dat_o   = grant_q ? m1_dat_i   : m0_dat_i;
         s_wr_o    = grant_q ? m1_wr_i    : m0_wr_i;
         s_wstrb_o = grant_q ? m1_wstrb_i : m0_wstrb_i;
         s_en_o    = gnt_en & ~ack_tmo;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         wdog_q    <= '0;
         timeout_q <= 1'b0;
         tcount_q  <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (m0_en_i | m1_en_i) begin
                  grant_q <= (m0_en_i & m1_en_i) ? ~last_q : m1_en_i;
                  wdog_q  <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               // Master withdrawing its request mid-flight is abandoned silently.
               if (!gnt_en) begin
                  state_q <= IDLE;
               end else if (done) begin
                  last_q  <= grant_q;
                  state_q <= GAP;
                  if (ack_tmo) begin
                     timeout_q <= 1'b1;
                     if (tcount_q != 8'hFF) tcount_q <= tcount_q + 8'd1;
                  end
               end else begin
                  wdog_q <= wdog_q + WDW'(1);
               end
            end
            GAP:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter: single read, round-robin alternation,
// watchdog timeout, ack on the timeout cycle, async reset and counter saturation.
module tb_regbus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] m0_adr_i, m1_adr_i;
   logic [31:0] m0_dat_i, m1_dat_i;
   logic        m0_en_i, m1_en_i, m0_wr_i, m1_wr_i;
   logic [3:0]  m0_wstrb_i, m1_wstrb_i;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_ack_o, m1_ack_o;
   logic [19:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic        s_en_o, s_wr_o;
   logic [3:0]  s_wstrb_o;
   logic [31:0] s_dat_i;
   logic        s_ack_i;
   logic        timeout_o;
   logic [7:0]  timeout_count_o;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   regbus_arbiter #(.TIMEOUT_CYCLES(16), .TIMEOUT_DATA(32'hBADACCE5)) dut (
      .clk(clk), .rst(rst),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_en_i(m0_en_i), .m0_wr_i(m0_wr_i),
      .m0_wstrb_i(m0_wstrb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_en_i(m1_en_i), .m1_wr_i(m1_wr_i),
      .m1_wstrb_i(m1_wstrb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_en_o(s_en_o), .s_wr_o(s_wr_o),
      .s_wstrb_o(s_wstrb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .timeout_o(timeout_o), .timeout_count_o(timeout_count_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      m0_adr_i = '0; m0_dat_i = '0; m0_en_i = 1'b0; m0_wr_i = 1'b0; m0_wstrb_i = '0;
      m1_adr_i = '0; m1_dat_i = '0; m1_en_i = 1'b0; m1_wr_i = 1'b0; m1_wstrb_i = '0;
      s_dat_i = '0; s_ack_i = 1'b0;
      #12;
      chk("rst_s_en", 32'(s_en_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      chk("rst_count", 32'(timeout_count_o), 32'd0);
      rst = 1'b1;
      tick();

      // single read from m0, slave acks on the third s_en cycle
      m0_en_i = 1'b1; m0_adr_i = 20'h00010; m0_wr_i = 1'b0;
      #1;
      chk("rd_idle_s_en", 32'(s_en_o), 32'd0);
      tick();
      chk("rd_b1_s_en", 32'(s_en_o), 32'd1);
      chk("rd_b1_adr", 32'(s_adr_o), 32'h00010);
      chk("rd_b1_ack", 32'(m0_ack_o), 32'd0);
      tick();
      chk("rd_b2_s_en", 32'(s_en_o), 32'd1);
      tick();
      s_ack_i = 1'b1; s_dat_i = 32'h12345678;
      #1;
      chk("rd_b3_s_en", 32'(s_en_o), 32'd1);
      chk("rd_m0_ack", 32'(m0_ack_o), 32'd1);
      chk("rd_m0_dat", m0_dat_o, 32'h12345678);
      chk("rd_m1_ack", 32'(m1_ack_o), 32'd0);
      chk("rd_m1_dat", m1_dat_o, 32'd0);
      tick();
      s_ack_i = 1'b0; m0_en_i = 1'b0;
      #1;
      chk("rd_gap_s_en", 32'(s_en_o), 32'd0);
      chk("rd_gap_ack", 32'(m0_ack_o), 32'd0);
      tick();

      // both masters write continuously; m0 just finished so m1 goes first
      m0_en_i = 1'b1; m0_wr_i = 1'b1; m0_adr_i = 20'h00100; m0_dat_i = 32'hAAAA0000; m0_wstrb_i = 4'h3;
      m1_en_i = 1'b1; m1_wr_i = 1'b1; m1_adr_i = 20'h00200; m1_dat_i = 32'h5555FFFF; m1_wstrb_i = 4'hC;
      for (int t = 0; t < 4; t++) begin
         automatic logic g = (t % 2 == 0);
         #1;
         chk("rr_idle_s_en", 32'(s_en_o), 32'd0);
         tick();
         chk("rr_s_en", 32'(s_en_o), 32'd1);
         chk("rr_wr", 32'(s_wr_o), 32'd1);
         chk("rr_wstrb", 32'(s_wstrb_o), g ? 32'hC : 32'h3);
         chk("rr_dat", s_dat_o, g ? 32'h5555FFFF : 32'hAAAA0000);
         tick();
         s_ack_i = 1'b1;
         #1;
         chk("rr_m0_ack", 32'(m0_ack_o), g ? 32'd0 : 32'd1);
         chk("rr_m1_ack", 32'(m1_ack_o), g ? 32'd1 : 32'd0);
         tick();
         s_ack_i = 1'b0;
         if (t == 3) begin
            m0_en_i = 1'b0; m1_en_i = 1'b0;
         end
         #1;
         chk("rr_gap_s_en", 32'(s_en_o), 32'd0);
         tick();
      end

      // m1 read to a silent slave times out after 16 BUSY cycles
      m1_en_i = 1'b1; m1_wr_i = 1'b0;
      tick();
      for (int i = 1; i < 16; i++) begin
         chk("to_wait_s_en", 32'(s_en_o), 32'd1);
         chk("to_wait_ack", 32'(m1_ack_o), 32'd0);
         tick();
      end
      chk("to_m1_ack", 32'(m1_ack_o), 32'd1);
      chk("to_m1_dat", m1_dat_o, 32'hBADACCE5);
      chk("to_s_en_forced", 32'(s_en_o), 32'd0);
      chk("to_pulse_early", 32'(timeout_o), 32'd0);
      tick();
      m1_en_i = 1'b0;
      chk("to_pulse", 32'(timeout_o), 32'd1);
      chk("to_count", 32'(timeout_count_o), 32'd1);
      tick();
      chk("to_pulse_end", 32'(timeout_o), 32'd0);
      m0_en_i = 1'b0;
      m0_en_i = 1'b1; m0_wr_i = 1'b0; m0_adr_i = 20'h00044;
      tick();
      chk("post_to_adr", 32'(s_adr_o), 32'h00044);
      s_ack_i = 1'b1; s_dat_i = 32'h0BADF00D;
      #1;
      chk("post_to_ack", 32'(m0_ack_o), 32'd1);
      chk("post_to_dat", m0_dat_o, 32'h0BADF00D);
      tick();
      s_ack_i = 1'b0; m0_en_i = 1'b0;
      tick();

      // ack arriving exactly on the watchdog's last cycle is a normal ack
      m0_en_i = 1'b1;
      tick();
      repeat (15) tick();
      s_ack_i = 1'b1; s_dat_i = 32'hCAFEF00D;
      #1;
      chk("co_ack", 32'(m0_ack_o), 32'd1);
      chk("co_dat", m0_dat_o, 32'hCAFEF00D);
      chk("co_s_en", 32'(s_en_o), 32'd1);
      tick();
      s_ack_i = 1'b0; m0_en_i = 1'b0;
      chk("co_no_pulse", 32'(timeout_o), 32'd0);
      chk("co_count", 32'(timeout_count_o), 32'd1);
      tick();

      // async reset in the middle of an m1 transaction
      m1_en_i = 1'b1; m1_adr_i = 20'h00300;
      tick();
      chk("ar_busy_s_en", 32'(s_en_o), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("ar_s_en_drop", 32'(s_en_o), 32'd0);
      chk("ar_no_ack", 32'(m1_ack_o), 32'd0);
      chk("ar_count_clr", 32'(timeout_count_o), 32'd0);
      m0_en_i = 1'b1; m0_adr_i = 20'h00055;
      rst = 1'b1;
      tick();
      chk("ar_first_m0", 32'(s_adr_o), 32'h00055);
      s_ack_i = 1'b1;
      #1;
      chk("ar_m0_ack", 32'(m0_ack_o), 32'd1);
      chk("ar_m1_ack", 32'(m1_ack_o), 32'd0);
      tick();
      s_ack_i = 1'b0; m0_en_i = 1'b0; m1_en_i = 1'b0;
      tick();

      // 300 forced timeouts saturate the counter at 255
      for (int n = 0; n < 300; n++) begin
         m0_en_i = 1'b1;
         tick();
         repeat (15) tick();
         tick();
         m0_en_i = 1'b0;
         if (n == 253) chk("sat_254", 32'(timeout_count_o), 32'd254);
         tick();
      end
      chk("sat_count", 32'(timeout_count_o), 32'hFF);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
